// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in serial-out transmitter
//
// Accepts WIDTH-bit words into a 2-entry word buffer and shifts each word out
// MSB-first on the receive-side clock, one bit per accepted serial handshake.
// Back-to-back words stream with no idle cycle between them.
//
// Optional feature macro: PISO_PARITY_EN
//   When defined, an even-parity bit (XOR of all data bits) follows the LSB
//   of every word, so each serial word is WIDTH+1 bits long.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready. The source keeps data and valid stable while valid && !ready.
// par_ready_out depends only on buffer occupancy, never on par_valid_in.
//
// Ports:
//   clk_rx_in      in   clock, rising edge
//   rst            in   asynchronous, active-high reset
//   par_data_in    in   [WIDTH-1:0] parallel word to transmit
//   par_valid_in   in   par_data_in is valid
//   par_ready_out  out  word buffer not full
//   ser_ready_in   in   downstream accepts the current serial bit
//   ser_data_out   out  current serial bit (registered)
//   ser_valid_out  out  ser_data_out is valid (registered)
//   word_done_out  out  one-cycle pulse after the final bit of a word is taken
//   busy_out       out  serializer active or buffer non-empty
//
// Internal state_q is the FSM state register and is the intended probe point
// for external checkers.
// -----------------------------------------------------------------------------
module piso_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk_rx_in,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_data_in,
   input  logic             par_valid_in,
   output logic             par_ready_out,
   input  logic             ser_ready_in,
   output logic             ser_data_out,
   output logic             ser_valid_out,
   output logic             word_done_out,
   output logic             busy_out
);

   localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   // Word buffer
   logic [WIDTH-1:0] buf_q [2];
   logic [WIDTH-1:0] buf_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   // Serializer
   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             ser_data_q, ser_data_d;
   logic             ser_valid_q, ser_valid_d;
   logic             word_done_q, word_done_d;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             push;
   logic             pop;
   logic             ser_fire;
   logic             word_end;
   logic [WIDTH-1:0] head;

   assign par_ready_out = (count_q != 2'd2);
   assign push          = par_valid_in && par_ready_out;
   assign ser_fire      = ser_valid_q && ser_ready_in;
   assign head          = buf_q[rd_ptr_q];

   assign ser_data_out  = ser_data_q;
   assign ser_valid_out = ser_valid_q;
   assign word_done_out = word_done_q;
   assign busy_out      = (state_q != IDLE) || (count_q != 2'd0);

   // Serializer next-state logic
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      ser_data_d  = ser_data_q;
      ser_valid_d = ser_valid_q;
      word_done_d = 1'b0;
      word_end    = 1'b0;
      pop         = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         IDLE: begin
            ser_valid_d = 1'b0;
            if (count_q != 2'd0) begin
               pop = 1'b1;
            end
         end
         SHIFT: begin
            if (ser_fire) begin
               if (bit_cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                  state_d    = PARITY;
                  ser_data_d = parity_q;
`else
                  word_end   = 1'b1;
`endif
               end else begin
                  // shift_q[WIDTH-1] is the bit just taken; present the next one.
                  shift_d    = shift_q << 1;
                  ser_data_d = shift_q[WIDTH-2];
                  bit_cnt_d  = bit_cnt_q - CW'(1);
               end
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            if (ser_fire) begin
               word_end = 1'b1;
            end
         end
`endif
         default: begin
            state_d     = IDLE;
            ser_valid_d = 1'b0;
         end
      endcase

      // Word completion: chain straight into the next buffered word so that
      // ser_valid stays high, otherwise drop back to IDLE.
      if (word_end) begin
         word_done_d = 1'b1;
         if (count_q != 2'd0) begin
            pop = 1'b1;
         end else begin
            state_d     = IDLE;
            ser_valid_d = 1'b0;
            ser_data_d  = 1'b0;
         end
      end

      if (pop) begin
         state_d     = SHIFT;
         shift_d     = head;
         ser_data_d  = head[WIDTH-1];
         ser_valid_d = 1'b1;
         bit_cnt_d   = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
         parity_d    = ^head;
`endif
      end
   end

   // Buffer next-state logic; push and pop together keep the count unchanged.
   always_comb begin
      buf_d = buf_q;
      if (push) begin
         buf_d[wr_ptr_q] = par_data_in;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst) begin
         buf_q[0]    <= '0;
         buf_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         ser_data_q  <= 1'b0;
         ser_valid_q <= 1'b0;
         word_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         buf_q       <= buf_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         ser_data_q  <= ser_data_d;
         ser_valid_q <= ser_valid_d;
         word_done_q <= word_done_d;
`ifdef PISO_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx -- directed, table-driven bench for piso_tx (WIDTH = 4).
//
// Each table row holds the inputs applied before one rising edge and the
// outputs expected just after that edge. Reset-mid-word and (when
// PISO_PARITY_EN is defined) the parity sequence are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_piso_tx;

   localparam int W = 4;

   logic         clk_rx_in = 1'b0;
   logic         rst       = 1'b1;
   logic [W-1:0] par_data_in  = '0;
   logic         par_valid_in = 1'b0;
   logic         par_ready_out;
   logic         ser_ready_in = 1'b0;
   logic         ser_data_out;
   logic         ser_valid_out;
   logic         word_done_out;
   logic         busy_out;

   int checks = 0;
   int errors = 0;

   piso_tx #(.WIDTH(W)) dut (
      .clk_rx_in     (clk_rx_in),
      .rst           (rst),
      .par_data_in   (par_data_in),
      .par_valid_in  (par_valid_in),
      .par_ready_out (par_ready_out),
      .ser_ready_in  (ser_ready_in),
      .ser_data_out  (ser_data_out),
      .ser_valid_out (ser_valid_out),
      .word_done_out (word_done_out),
      .busy_out      (busy_out)
   );

   // ---------------- clock ----------------
   always #5 clk_rx_in = ~clk_rx_in;

   // ---------------- vector table ----------------
   typedef struct {
      logic         pv;
      logic [W-1:0] pd;
      logic         sr;
      logic         e_v;
      logic         e_d;
      logic         e_wd;
      logic         e_pr;
      logic         e_b;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic pv, input logic [W-1:0] pd, input logic sr,
                      input logic v, input logic d, input logic wd,
                      input logic pr, input logic b);
      vec_t x;
      x.pv = pv; x.pd = pd; x.sr = sr;
      x.e_v = v; x.e_d = d; x.e_wd = wd; x.e_pr = pr; x.e_b = b;
      vecs.push_back(x);
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string name, input int idx, input logic act,
                      input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic v, input logic d,
                          input logic wd, input logic pr, input logic b);
      chk("ser_valid", idx, ser_valid_out, v);
      chk("ser_data",  idx, ser_data_out,  d);
      chk("word_done", idx, word_done_out, wd);
      chk("par_ready", idx, par_ready_out, pr);
      chk("busy",      idx, busy_out,      b);
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic pv, input logic [W-1:0] pd, input logic sr);
      @(negedge clk_rx_in);
      par_valid_in = pv;
      par_data_in  = pd;
      ser_ready_in = sr;
      @(posedge clk_rx_in);
      #1;
   endtask

   // ---------------- test ----------------
   initial begin
      // Reset state
      #12;
      chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk_rx_in);
      rst = 1'b0;

`ifndef PISO_PARITY_EN
      //   pv  pd    sr   v  d  wd pr b
      // Single word 1011, ready held high
      add(1, 4'hB, 1,   0, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   0, 0, 1, 1, 0);
      add(0, 4'h0, 1,   0, 0, 0, 1, 0);
      // Back-to-back A then 5: eight valid bits, no gap
      add(1, 4'hA, 1,   0, 0, 0, 1, 1);
      add(1, 4'h5, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 1, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   0, 0, 1, 1, 0);
      add(0, 4'h0, 1,   0, 0, 0, 1, 0);
      // Backpressure on 1100: second bit held for three stalled edges
      add(1, 4'hC, 1,   0, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 0,   1, 1, 0, 1, 1);
      add(0, 4'h0, 0,   1, 1, 0, 1, 1);
      add(0, 4'h0, 0,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   0, 0, 1, 1, 0);
      add(0, 4'h0, 1,   0, 0, 0, 1, 0);
      // Buffer full: 1 popped, 2 and 3 fill buffer, 4 refused
      add(1, 4'h1, 0,   0, 0, 0, 1, 1);
      add(1, 4'h2, 0,   1, 0, 0, 1, 1);
      add(1, 4'h3, 0,   1, 0, 0, 0, 1);
      add(1, 4'h4, 0,   1, 0, 0, 0, 1);
      add(0, 4'h0, 1,   1, 0, 0, 0, 1);
      add(0, 4'h0, 1,   1, 0, 0, 0, 1);
      add(0, 4'h0, 1,   1, 1, 0, 0, 1);
      add(0, 4'h0, 1,   1, 0, 1, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 0, 1, 1, 1);
      add(0, 4'h0, 1,   1, 0, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   1, 1, 0, 1, 1);
      add(0, 4'h0, 1,   0, 0, 1, 1, 0);
      add(0, 4'h0, 1,   0, 0, 0, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].pv, vecs[i].pd, vecs[i].sr);
         chk_all(i, vecs[i].e_v, vecs[i].e_d, vecs[i].e_wd, vecs[i].e_pr,
                 vecs[i].e_b);
      end
`else
      // Parity: 1011 followed by parity bit 1; done only after parity bit
      step(1, 4'hB, 1); chk_all(200, 0, 0, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(201, 1, 1, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(202, 1, 0, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(203, 1, 1, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(204, 1, 1, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(205, 1, 1, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(206, 0, 0, 1, 1, 0);
      step(0, 4'h0, 1); chk_all(207, 0, 0, 0, 1, 0);
`endif

      // Reset mid-word: F in flight with 6 buffered
      step(1, 4'hF, 1); chk_all(100, 0, 0, 0, 1, 1);
      step(1, 4'h6, 1); chk_all(101, 1, 1, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(102, 1, 1, 0, 1, 1);
      step(0, 4'h0, 1); chk_all(103, 1, 1, 0, 1, 1);
      @(negedge clk_rx_in);
      rst = 1'b1;
      #1;
      chk_all(104, 0, 0, 0, 1, 0);
      @(negedge clk_rx_in);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(0, 4'h0, 1);
         chk_all(110 + i, 0, 0, 0, 1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
